// File: rtl/sw_led_pkg.sv
// rtl/sw_led_pkg.sv - shared constants and helpers for the switch debounce / LED count block
// Optional sw_rise edge outputs are built in when SW_LED_EDGE_EN is defined.
package sw_led_pkg;

   localparam int DEB_CYCLES_DEF = 16;

   // Widest switch bank the popcount helper accepts; narrower vectors are zero-extended.
   localparam int POP_MAX_W = 64;
   localparam int POP_W     = $clog2(POP_MAX_W + 1);

   function automatic int cnt_w(input int n);
      return $clog2(n + 1);
   endfunction

   function automatic logic [POP_W-1:0] popcount(input logic [POP_MAX_W-1:0] v);
      logic [POP_W-1:0] n;
      n = '0;
      for (int i = 0; i < POP_MAX_W; i++) begin
         n = n + POP_W'(v[i]);
      end
      return n;
   endfunction

endpackage

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - one switch channel: 2-flop synchroniser, stability counter, accepted level
// The o_rise edge pulse exists only when SW_LED_EDGE_EN is defined.
module sw_debounce
   import sw_led_pkg::*;
#(
   parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_sw,
   output logic o_db,
   output logic o_chg
`ifdef SW_LED_EDGE_EN
   ,
   output logic o_rise
`endif
);

   localparam int CW = $clog2(DEB_CYCLES);
   localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

   logic          r_s1;
   logic          r_s2;
   logic [CW-1:0] r_cnt;
   logic          r_db;
   logic          r_chg;
   logic          w_accept;

   assign w_accept = (r_s2 != r_db) && (r_cnt == CNT_MAX);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1  <= 1'b0;
         r_s2  <= 1'b0;
         r_cnt <= '0;
         r_db  <= 1'b0;
         r_chg <= 1'b0;
      end else begin
         r_s1  <= i_sw;
         r_s2  <= r_s1;
         r_chg <= w_accept;
         // Any return to the accepted level throws away partial progress.
         if (r_s2 == r_db) begin
            r_cnt <= '0;
         end else if (w_accept) begin
            r_db  <= r_s2;
            r_cnt <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end
   end

`ifdef SW_LED_EDGE_EN
   logic r_rise;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rise <= 1'b0;
      end else begin
         r_rise <= w_accept & r_s2;
      end
   end

   assign o_rise = r_rise;
`endif

   assign o_db  = r_db;
   assign o_chg = r_chg;

endmodule

// File: rtl/sw_led_debounce.sv
// rtl/sw_led_debounce.sv - debounced switch bank with registered LED count and update strobe
// Defining SW_LED_EDGE_EN adds the per-channel sw_rise pulse port.
module sw_led_debounce
   import sw_led_pkg::*;
#(
   parameter int  SW_W       = 8,
   parameter int  DEB_CYCLES = DEB_CYCLES_DEF,
   localparam int CNT_W      = cnt_w(SW_W)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [SW_W-1:0]  sw_in,
   output logic [SW_W-1:0]  sw_db,
   output logic [CNT_W-1:0] led_cnt,
   output logic             led_valid
`ifdef SW_LED_EDGE_EN
   ,
   output logic [SW_W-1:0]  sw_rise
`endif
);

   logic [SW_W-1:0]  w_chg;
   logic [CNT_W-1:0] r_led_cnt;
   logic             r_led_valid;

   for (genvar i = 0; i < SW_W; i++) begin : g_ch
      sw_debounce #(
         .DEB_CYCLES (DEB_CYCLES)
      ) u_deb (
         .clk    (clk),
         .rst    (rst),
         .i_sw   (sw_in[i]),
         .o_db   (sw_db[i]),
         .o_chg  (w_chg[i])
`ifdef SW_LED_EDGE_EN
         ,
         .o_rise (sw_rise[i])
`endif
      );
   end

   // w_chg is already registered alongside sw_db, so this strobe lines up with the reloaded count.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_led_cnt   <= '0;
         r_led_valid <= 1'b0;
      end else begin
         r_led_cnt   <= CNT_W'(popcount(POP_MAX_W'(sw_db)));
         r_led_valid <= |w_chg;
      end
   end

   assign led_cnt   = r_led_cnt;
   assign led_valid = r_led_valid;

endmodule

// File: tb/tb_sw_led_debounce.sv
// tb/tb_sw_led_debounce.sv - self-checking bench for sw_led_debounce (SW_LED_EDGE_EN optional)
module tb_sw_led_debounce;

   localparam int SW  = 8;
   localparam int DEB = 16;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic [7:0] sw_in = 8'h00;
   logic [7:0] sw_db;
   logic [3:0] led_cnt;
   logic       led_valid;
`ifdef SW_LED_EDGE_EN
   logic [7:0] sw_rise;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   sw_led_debounce #(
      .SW_W       (SW),
      .DEB_CYCLES (DEB)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .sw_in     (sw_in),
      .sw_db     (sw_db),
      .led_cnt   (led_cnt),
      .led_valid (led_valid)
`ifdef SW_LED_EDGE_EN
      ,
      .sw_rise   (sw_rise)
`endif
   );

   // Reference: a channel takes a new level once the last DEB synchronised samples
   // (raw input two edges old) all disagree with the current level.
   logic [7:0] q[$];
   logic [7:0] m_db    = 8'h00;
   logic [7:0] m_rise  = 8'h00;
   logic [3:0] m_cnt   = 4'h0;
   logic       m_valid = 1'b0;
   logic       m_chg   = 1'b0;
   logic [7:0] m_nd;
   bit         m_flip;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         q.delete();
         for (int i = 0; i <= DEB; i++) q.push_back(8'h00);
         m_db = 8'h00; m_rise = 8'h00; m_cnt = 4'h0; m_valid = 1'b0; m_chg = 1'b0;
      end else begin
         m_cnt   = 4'($countones(m_db));
         m_valid = m_chg;
         m_nd    = m_db;
         for (int c = 0; c < SW; c++) begin
            m_flip = 1'b1;
            for (int k = 1; k <= DEB; k++) if (q[k][c] == m_db[c]) m_flip = 1'b0;
            if (m_flip) m_nd[c] = ~m_db[c];
         end
         m_rise = m_nd & ~m_db;
         m_chg  = (m_nd != m_db);
         m_db   = m_nd;
         q.push_front(sw_in);
         void'(q.pop_back());
      end
   end

   task automatic apply_reset(input logic [7:0] v);
      @(negedge clk);
      sw_in = v;
      rst   = 1'b1;
      repeat (3) @(negedge clk);
      rst   = 1'b0;
   endtask

   task automatic test_reset();
      @(negedge clk);
      sw_in = 8'hFF;
      rst   = 1'b1;
      repeat (2) @(negedge clk);
      total++; if (sw_db !== 8'h00) begin bad++; $display("FAIL reset_db got=%h exp=00", sw_db); end
      total++; if (led_cnt !== 4'd0) begin bad++; $display("FAIL reset_cnt got=%0d exp=0", led_cnt); end
      total++; if (led_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", led_valid); end
      rst = 1'b0;
      for (int k = 1; k <= 21; k++) begin
         @(negedge clk);
         if (k == 17) begin
            total++; if (sw_db !== 8'h00) begin bad++; $display("FAIL reset_early got=%h exp=00", sw_db); end
         end
         if (k == 18) begin
            total++; if (sw_db !== 8'hFF || led_valid !== 1'b0) begin
               bad++; $display("FAIL reset_lat got=%h/%b exp=ff/0", sw_db, led_valid); end
         end
         if (k == 19) begin
            total++; if (led_cnt !== 4'd8 || led_valid !== 1'b1) begin
               bad++; $display("FAIL reset_cnt8 got=%0d/%b exp=8/1", led_cnt, led_valid); end
         end
         if (k == 20) begin
            total++; if (led_valid !== 1'b0) begin bad++; $display("FAIL reset_pulse got=%b exp=0", led_valid); end
         end
      end
   endtask

   task automatic test_single();
      apply_reset(8'h00);
      repeat (25) @(negedge clk);
      sw_in = 8'h01;
      for (int k = 1; k <= 21; k++) begin
         @(negedge clk);
         if (k == 17) begin
            total++; if (sw_db !== 8'h00) begin bad++; $display("FAIL single_early got=%h exp=00", sw_db); end
         end
         if (k == 18) begin
            total++; if (sw_db !== 8'h01) begin bad++; $display("FAIL single_db got=%h exp=01", sw_db); end
`ifdef SW_LED_EDGE_EN
            total++; if (sw_rise !== 8'h01) begin bad++; $display("FAIL single_rise got=%h exp=01", sw_rise); end
`endif
         end
         if (k == 19) begin
            total++; if (led_cnt !== 4'd1 || led_valid !== 1'b1) begin
               bad++; $display("FAIL single_cnt got=%0d/%b exp=1/1", led_cnt, led_valid); end
`ifdef SW_LED_EDGE_EN
            total++; if (sw_rise !== 8'h00) begin bad++; $display("FAIL single_rise_end got=%h exp=00", sw_rise); end
`endif
         end
      end
   endtask

   task automatic test_glitch();
      apply_reset(8'h01);
      repeat (25) @(negedge clk);
      sw_in = 8'h09;
      repeat (15) @(negedge clk);
      sw_in = 8'h01;
      for (int k = 1; k <= 30; k++) begin
         @(negedge clk);
         total++; if (sw_db !== 8'h01 || led_cnt !== 4'd1 || led_valid !== 1'b0) begin
            bad++; $display("FAIL glitch15 got=%h/%0d/%b exp=01/1/0", sw_db, led_cnt, led_valid); end
      end
      sw_in = 8'h09;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (k == 16) sw_in = 8'h01;
         if (k == 17) begin
            total++; if (sw_db !== 8'h01) begin bad++; $display("FAIL glitch16_early got=%h exp=01", sw_db); end
         end
         if (k == 18) begin
            total++; if (sw_db !== 8'h09) begin bad++; $display("FAIL glitch16 got=%h exp=09", sw_db); end
         end
      end
      repeat (30) @(negedge clk);
   endtask

   task automatic test_swap();
      int vcount;
      vcount = 0;
      apply_reset(8'h01);
      repeat (25) @(negedge clk);
      sw_in = 8'h02;
      for (int k = 1; k <= 25; k++) begin
         @(negedge clk);
         if (led_valid === 1'b1) vcount++;
         if (k == 17) begin
            total++; if (sw_db !== 8'h01) begin bad++; $display("FAIL swap_early got=%h exp=01", sw_db); end
         end
         if (k == 18) begin
            total++; if (sw_db !== 8'h02) begin bad++; $display("FAIL swap_db got=%h exp=02", sw_db); end
         end
         if (k == 19) begin
            total++; if (led_cnt !== 4'd1 || led_valid !== 1'b1) begin
               bad++; $display("FAIL swap_cnt got=%0d/%b exp=1/1", led_cnt, led_valid); end
         end
      end
      total++; if (vcount != 1) begin bad++; $display("FAIL swap_pulses got=%0d exp=1", vcount); end
   endtask

   task automatic test_bounce();
      apply_reset(8'h00);
      repeat (5) @(negedge clk);
      for (int t = 0; t < 100; t++) begin
         if (t % 5 == 0) sw_in[0] = ~sw_in[0];
         @(negedge clk);
         total++; if (sw_db !== 8'h00 || sw_db !== m_db) begin
            bad++; $display("FAIL bounce_hold got=%h model=%h exp=00", sw_db, m_db); end
      end
      sw_in[0] = 1'b1;
      for (int k = 1; k <= 19; k++) begin
         @(negedge clk);
         if (k == 17) begin
            total++; if (sw_db !== 8'h00) begin bad++; $display("FAIL bounce_early got=%h exp=00", sw_db); end
         end
         if (k == 18) begin
            total++; if (sw_db !== 8'h01) begin bad++; $display("FAIL bounce_db got=%h exp=01", sw_db); end
         end
      end
   endtask

   task automatic test_reset_mid();
      apply_reset(8'h00);
      repeat (5) @(negedge clk);
      sw_in = 8'h01;
      repeat (10) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      total++; if (sw_db !== 8'h00 || led_cnt !== 4'd0) begin
         bad++; $display("FAIL midrst_in got=%h/%0d exp=00/0", sw_db, led_cnt); end
      rst = 1'b0;
      for (int k = 1; k <= 19; k++) begin
         @(negedge clk);
         if (k == 17) begin
            total++; if (sw_db !== 8'h00) begin bad++; $display("FAIL midrst_early got=%h exp=00", sw_db); end
         end
         if (k == 18) begin
            total++; if (sw_db !== 8'h01) begin bad++; $display("FAIL midrst_db got=%h exp=01", sw_db); end
         end
      end
   endtask

   task automatic test_random();
      int hold;
      hold = 0;
      apply_reset(8'($urandom));
      for (int n = 0; n < 3000; n++) begin
         if (hold == 0) begin
            if ($urandom_range(0, 1) == 0) begin
               sw_in = 8'($urandom);
               hold  = $urandom_range(10, 30);
            end else begin
               sw_in[$urandom_range(0, 7)] ^= 1'b1;
               hold  = $urandom_range(1, 20);
            end
         end
         hold--;
         @(negedge clk);
         total++; if (sw_db !== m_db || led_cnt !== m_cnt || led_valid !== m_valid) begin
            bad++; $display("FAIL random got=%h/%0d/%b exp=%h/%0d/%b", sw_db, led_cnt, led_valid, m_db, m_cnt, m_valid);
         end
`ifdef SW_LED_EDGE_EN
         total++; if (sw_rise !== m_rise) begin bad++; $display("FAIL random_rise got=%h exp=%h", sw_rise, m_rise); end
`endif
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_glitch();
      test_swap();
      test_bounce();
      test_reset_mid();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
